// File: rtl/pulse_race_pkg.sv
// Shared types and helpers for the pulse race capture block.
package pulse_race_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2
   } race_state_e;

   // Channel-index width; a single channel still needs one bit.
   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pulse_race_capture_edge.sv
// Per-channel rising-edge detector. When PULSE_SYNC_EN is defined the raw pulse
// first passes through a 2-flop synchroniser.
module pulse_edge_sync (
   input  logic clk,
   input  logic rst_b,
   input  logic pulse_in,
   output logic rise
);

   logic level;
   logic prev;

`ifdef PULSE_SYNC_EN
   logic [1:0] sync;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) sync <= '0;
      else        sync <= {sync[0], pulse_in};
   end

   assign level = sync[1];
`else
   assign level = pulse_in;
`endif

   // Tracks the level in every state so a channel already high at arming never counts.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) prev <= 1'b0;
      else        prev <= level;
   end

   assign rise = level & ~prev;

endmodule

// File: rtl/pulse_race_capture.sv
// N-channel pulse arrival capture: timestamps the first edge per channel inside an
// armed window and reports the earliest channel. Optional build macro: PULSE_SYNC_EN.
module pulse_race_capture
   import pulse_race_pkg::*;
#(
   parameter  int N_CH   = 2,
   parameter  int TS_W   = 8,
   parameter  int WINDOW = 200,
   localparam int ID_W   = id_w(N_CH)
) (
   input  logic                      clk,
   input  logic                      rst_b,
   input  logic                      start,
   input  logic [N_CH-1:0]           pulse_in,
   output logic [N_CH-1:0]           edge_seen,
   output logic [N_CH-1:0][TS_W-1:0] ts,
   output logic [ID_W-1:0]           first_id,
   output logic                      first_vld,
   output logic                      timeout,
   output logic                      valid,
   input  logic                      ready
);

   race_state_e     state, state_nx;
   logic [TS_W-1:0] cnt;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] cap;
   logic [ID_W-1:0] cap_id;
   logic            all_seen;
   logic            expire;

   for (genvar i = 0; i < N_CH; i++) begin : g_edge
      pulse_edge_sync u_edge (
         .clk      (clk),
         .rst_b    (rst_b),
         .pulse_in (pulse_in[i]),
         .rise     (rise[i])
      );
   end

   assign cap      = (state == ARMED) ? (rise & ~edge_seen) : '0;
   assign all_seen = &(edge_seen | cap);
   assign expire   = (cnt == TS_W'(WINDOW - 1));

   // Lowest index wins when several channels arrive in the same cycle.
   always_comb begin
      cap_id = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (cap[i]) cap_id = ID_W'(i);
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start)              state_nx = ARMED;
         ARMED:   if (all_seen || expire) state_nx = DONE;
         DONE:    if (ready)              state_nx = IDLE;
         default:                         state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt       <= '0;
         edge_seen <= '0;
         ts        <= '0;
         first_id  <= '0;
         first_vld <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt       <= '0;
                  edge_seen <= '0;
                  ts        <= '0;
                  first_id  <= '0;
                  first_vld <= 1'b0;
                  timeout   <= 1'b0;
               end
            end
            ARMED: begin
               cnt       <= cnt + 1'b1;
               edge_seen <= edge_seen | cap;
               for (int i = 0; i < N_CH; i++) begin
                  if (cap[i]) ts[i] <= cnt;
               end
               if (!first_vld && (|cap)) begin
                  first_vld <= 1'b1;
                  first_id  <= cap_id;
               end
               // A full set of arrivals in the expiry cycle is not a timeout.
               if (expire && !all_seen) timeout <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign valid = (state == DONE);

endmodule

// File: tb/tb_pulse_race_capture.sv
// Scoreboard bench for pulse_race_capture: randomized and directed pulse races
// against a per-cycle behavioural model of the arrival rules.
module tb_pulse_race_capture;

   localparam int N_CH   = 4;
   localparam int TS_W   = 8;
   localparam int WINDOW = 200;
`ifdef PULSE_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif
   localparam int PRE = 4;
   localparam int LEN = WINDOW + PRE;

   logic                      clk = 1'b0;
   logic                      rst_b = 1'b0;
   logic                      start = 1'b0;
   logic                      ready = 1'b0;
   logic [N_CH-1:0]           pulse_in = '0;
   logic [N_CH-1:0]           edge_seen;
   logic [N_CH-1:0][TS_W-1:0] ts;
   logic [1:0]                first_id;
   logic                      first_vld;
   logic                      timeout;
   logic                      valid;
   logic [31:0]               ts_flat;

   assign ts_flat = ts;

   pulse_race_capture #(.N_CH(N_CH), .TS_W(TS_W), .WINDOW(WINDOW)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .start     (start),
      .pulse_in  (pulse_in),
      .edge_seen (edge_seen),
      .ts        (ts),
      .first_id  (first_id),
      .first_vld (first_vld),
      .timeout   (timeout),
      .valid     (valid),
      .ready     (ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   logic hs = 1'b0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      hs  <= valid && ready;
   end

   typedef struct packed {
      logic [3:0]  seen;
      logic [31:0] ts;
      logic [1:0]  id;
      logic        fv;
      logic        to;
      int          vcyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   logic lvl [N_CH][LEN];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
      end
   endtask

   function automatic logic lv(input int ch, input int a);
      int i;
      i = a + PRE;
      if (i < 0 || i >= LEN) return 1'b0;
      return lvl[ch][i];
   endfunction

   // Walk the window cycle by cycle applying the arrival rules to the driven levels.
   task automatic run_model(output exp_t e, output int ea);
      logic [3:0] cap;
      e  = '0;
      ea = WINDOW - 1;
      for (int a = 0; a < WINDOW; a++) begin
         cap = '0;
         for (int ch = 0; ch < N_CH; ch++)
            if (lv(ch, a - LAT) && !lv(ch, a - LAT - 1) && !e.seen[ch]) cap[ch] = 1'b1;
         for (int ch = 0; ch < N_CH; ch++)
            if (cap[ch]) e.ts[ch*8 +: 8] = 8'(a);
         if (!e.fv && cap != 0) begin
            e.fv = 1'b1;
            for (int ch = 0; ch < N_CH; ch++)
               if (cap[ch]) begin e.id = 2'(ch); break; end
         end
         e.seen = e.seen | cap;
         if (&e.seen) begin ea = a; break; end
         if (a == WINDOW - 1) e.to = 1'b1;
      end
   endtask

   task automatic clr_lvl();
      for (int ch = 0; ch < N_CH; ch++)
         for (int i = 0; i < LEN; i++) lvl[ch][i] = 1'b0;
   endtask

   task automatic put_pulse(input int ch, input int a, input int w);
      for (int k = 0; k < w; k++)
         if (a + PRE + k >= 0 && a + PRE + k < LEN) lvl[ch][a + PRE + k] = 1'b1;
   endtask

   task automatic gap();
      repeat (4) begin
         @(negedge clk);
         pulse_in = '0; start = 1'b0; ready = 1'b0;
      end
   endtask

   task automatic run_tx(input int hold, input bit early_ready);
      exp_t e;
      int   ea;
      int   tmr;
      run_model(e, ea);
      for (int a = -PRE; a <= ea; a++) begin
         @(negedge clk);
         for (int ch = 0; ch < N_CH; ch++) pulse_in[ch] = lvl[ch][a + PRE];
         start = (a == -1) ? 1'b1 : ((a >= 0) ? 1'($urandom % 2) : 1'b0);
         ready = early_ready;
         if (a == 0) begin
            e.vcyc = cyc + ea + 1;
            sb.push_back(e);
         end
      end
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         pulse_in = '0; start = 1'b1; ready = 1'b0;
      end
      @(negedge clk);
      pulse_in = '0; start = 1'b0; ready = 1'b1;
      tmr = 0;
      while (valid && tmr < 20) begin
         @(negedge clk);
         tmr++;
      end
      gap();
   endtask

   // Monitor: pops on each new result, then checks the result holds and valid drops after transfer.
   exp_t cur;
   logic pv = 1'b0;
   initial begin
      cur = '0;
      forever begin
         @(negedge clk);
         if (rst_b) begin
            if (hs) chk("valid_drop", valid, 0);
            if (valid && !pv) begin
               if (sb.size() == 0) chk("spurious_valid", 1, 0);
               else begin
                  cur = sb.pop_front();
                  chk("valid_cycle", cyc, cur.vcyc);
                  chk("edge_seen", edge_seen, cur.seen);
                  chk("ts", ts_flat, cur.ts);
                  chk("first_vld", first_vld, cur.fv);
                  chk("first_id", first_id, cur.id);
                  chk("timeout", timeout, cur.to);
               end
            end else if (valid && pv) begin
               chk("hold_result", {edge_seen, ts_flat, first_id, first_vld, timeout},
                   {cur.seen, cur.ts, cur.id, cur.fv, cur.to});
            end
         end
         pv = valid;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      #2;
      chk("rst_valid", valid, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_first_vld", first_vld, 0);
      chk("rst_first_id", first_id, 0);
      chk("rst_edge_seen", edge_seen, 0);
      chk("rst_ts", ts_flat, 0);
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      gap();

      // ordered race
      clr_lvl();
      put_pulse(1, 5, 2); put_pulse(0, 9, 2); put_pulse(3, 20, 2); put_pulse(2, 30, 2);
      run_tx(0, 1'b0);
      // tie between channels 2 and 3
      clr_lvl();
      put_pulse(2, 3, 2); put_pulse(3, 3, 2); put_pulse(0, 7, 2); put_pulse(1, 8, 2);
      run_tx(1, 1'b0);
      // timeout with ready held low
      clr_lvl();
      put_pulse(0, 10, 3);
      run_tx(5, 1'b0);
      // level high before arming, repeated edges
      clr_lvl();
      for (int i = 0; i < LEN; i++) lvl[0][i] = 1'b1;
      put_pulse(1, 4, 2); put_pulse(1, 8, 2);
      run_tx(0, 1'b1);

      // reset mid-window
      @(negedge clk); start = 1'b1;
      for (int a = 0; a <= 50; a++) begin
         @(negedge clk);
         start = 1'b0;
         pulse_in = (a == 3 || a == 4) ? 4'b0100 : 4'b0000;
      end
      chk("pre_rst_seen", edge_seen, 4'b0100);
      #2 rst_b = 1'b0;
      #1;
      chk("mid_rst_valid", valid, 0);
      chk("mid_rst_timeout", timeout, 0);
      chk("mid_rst_first_vld", first_vld, 0);
      chk("mid_rst_first_id", first_id, 0);
      chk("mid_rst_edge_seen", edge_seen, 0);
      chk("mid_rst_ts", ts_flat, 0);
      @(negedge clk); rst_b = 1'b1;
      gap();

      // randomized races
      for (int t = 0; t < 16; t++) begin
         clr_lvl();
         for (int ch = 0; ch < N_CH; ch++) begin
            if ($urandom_range(0, 9) != 0) begin
               int np;
               np = $urandom_range(1, 3);
               for (int p = 0; p < np; p++)
                  put_pulse(ch, $urandom_range(0, 70) - PRE, $urandom_range(2, 4));
            end
         end
         if ($urandom % 2 == 1) run_tx(0, 1'b1);
         else                   run_tx($urandom_range(0, 4), 1'b0);
      end

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
